ras_ctrl: RTL and testbench
===========================

# ras_ctrl

Speculation controller for the fetch-stage return address stack. It records every RAS operation issued by fetch in a small checkpoint FIFO, releases entries as the owning control-transfer instructions retire, and on a pipeline flush unwinds the non-retired operations youngest-first. Unwinding is done by driving one corrective command per cycle into the RAS restore path, so the RAS returns to its architecturally committed state. It sits between the fetch stage, which is the RAS user, and the commit/flush logic.

## Interface
Parameters:
- DEPTH, 8: checkpoint FIFO entries; power of two, ≥2.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- req_valid_i  in  1  fetch issues a RAS operation this cycle
- req_op_i  in  2  ras_op_e: NONE, PUSH, POP or BOTH
- req_top_i  in  XLEN  RAS top value before the operation
- req_ready_o  out  1  operation may be accepted
- retire_i  in  1  oldest recorded operation is committed
- flush_i  in  1  discard all non-retired operations
- ras_cmd_valid_o  out  1  corrective command to the RAS
- ras_cmd_op_o  out  2  ras_op_e of the corrective command
- ras_cmd_addr_o  out  XLEN  address for the corrective command
- busy_o  out  1  unwind in progress; fetch must stall
- unwind_done_o  out  1  single-cycle pulse when unwind completes
- count_o  out  $clog2(DEPTH)+1  occupied entries

## Operation
- FIFO entry: {op, saved_top}. Head is the oldest entry, tail the youngest.
- Accept rule: req_valid_i && req_ready_o && req_op_i != NONE. The accepted operation is written at the tail.
  - NONE is never recorded.
  - req_ready_o = !full && state == IDLE.
- Retire: retire_i in IDLE removes the head entry.
  - Retire while empty is ignored and flagged by a simulation assertion.
- Simultaneous accept and retire in IDLE: both take effect, and count is unchanged.
- FSM states: IDLE, UNWIND.
  - IDLE→UNWIND on flush_i when the post-retire count > 0.
  - Any request in the flush cycle is dropped.
  - Retire in the flush cycle is applied before the flush.
  - IDLE stays IDLE on flush_i with count 0; unwind_done_o pulses in the next cycle.
  - UNWIND issues one command per cycle from the tail, decrementing count.
  - UNWIND→IDLE after the last entry; unwind_done_o pulses in the cycle after the final command.
- Inverse commands:
  - Recorded PUSH → command POP, addr 0.
  - Recorded POP → command PUSH, addr saved_top.
  - Recorded BOTH → command BOTH, meaning overwrite top, addr saved_top.
- In UNWIND, flush_i, retire_i and req_valid_i are ignored. retire_i high during UNWIND fires an assertion.
- Pointer wrap: modulo DEPTH. Full when count == DEPTH; empty when count == 0.

## Timing
- Reset values: state IDLE, count 0, pointers 0, ras_cmd_valid_o 0, ras_cmd_op_o NONE, ras_cmd_addr_o 0, busy_o 0, unwind_done_o 0, req_ready_o 1.
- Accepted requests become visible in count_o one cycle later.
- First corrective command is registered and appears one cycle after flush_i. N entries take N consecutive cycles.
- busy_o is high from the cycle after flush_i until the unwind_done_o cycle, exclusive.
- All outputs are registered except req_ready_o, which is combinational from state and count.
- Reset mid-unwind: the next cycle is the reset state. No further commands are issued and no done pulse is generated.

## Configuration
- RAS_CTRL_PERF_EN defined: adds two 32-bit saturating counters, readable on perf_unwind_o and perf_full_stall_o.
  - perf_unwind_o counts flushes that entered UNWIND.
  - perf_full_stall_o counts cycles with req_valid_i && op != NONE && full.
  - Both reset to 0.
- RAS_CTRL_PERF_EN undefined: those ports and counters do not exist, and behaviour is otherwise identical.

## Structure
- tcore_param holds ras_op_e (NONE=0, PUSH=1, POP=2, BOTH=3), moved there so it is shared with the RAS, plus XLEN and a ras_ckpt_t struct {op, saved_top}.
- One sub-module: ras_ckpt_fifo. It is a circular buffer with head pop and tail pop (LIFO read for unwind) and exposes count, full and empty. The FSM and command generation stay in ras_ctrl.

## Test plan
- Push 0x100, push 0x200, pop saving top 0x200, then flush → commands in order PUSH 0x200, POP, POP over 3 cycles; unwind_done_o pulses in cycle 4; count 0.
- Push 0x100, retire, then flush → no commands; done pulses in the next cycle; count 0.
- DEPTH=8: issue 9 PUSH requests back-to-back → req_ready_o drops after 8; the 9th is held; count 8; with PERF_EN, perf_full_stall_o ≥ 1.
- Accept BOTH (top 0x300) and retire in the same cycle with count 2 → count stays 2; a following flush yields a first command BOTH 0x300.
- Flush with 3 entries, assert rst_i in the second UNWIND cycle → the next cycle has ras_cmd_valid_o 0, busy_o 0, count 0, and no done pulse.
- Requests with NONE for 10 cycles → count stays 0; req_ready_o stays 1.

Source files
------------

// File: rtl/tcore_param.sv
// Shared core types: RAS operation encoding, checkpoint entry layout and the
// inverse-operation helper used to undo speculative RAS updates.
package tcore_param;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    PUSH = 2'd1,
    POP  = 2'd2,
    BOTH = 2'd3
  } ras_op_e;

  typedef enum logic {
    IDLE   = 1'b0,
    UNWIND = 1'b1
  } ras_ctrl_state_e;

  typedef struct packed {
    ras_op_e          op;
    logic [XLEN-1:0]  saved_top;
  } ras_ckpt_t;

  // BOTH overwrites the top in place, so its undo is another overwrite.
  function automatic ras_ckpt_t ras_inverse(input ras_ckpt_t e);
    ras_ckpt_t c;
    c = '0;
    case (e.op)
      PUSH:    c.op = POP;
      POP:     begin c.op = PUSH; c.saved_top = e.saved_top; end
      BOTH:    begin c.op = BOTH; c.saved_top = e.saved_top; end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ras_ckpt_fifo.sv
// Circular checkpoint buffer: tail push, head pop for retirement and tail pop
// for youngest-first unwind.
module ras_ckpt_fifo
  import tcore_param::*;
#(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            i_push,
  input  ras_ckpt_t       i_push_data,
  input  logic            i_pop_head,
  input  logic            i_pop_tail,
  output ras_ckpt_t       o_tail_data,
  output logic [CW-1:0]   o_count,
  output logic            o_full,
  output logic            o_empty
);

  ras_ckpt_t         r_mem [DEPTH];
  logic [AW-1:0]     r_head;
  logic [AW-1:0]     r_tail;
  logic [CW-1:0]     r_count;
  logic [AW-1:0]     w_tail_m1;

  assign w_tail_m1   = r_tail - AW'(1);
  assign o_tail_data = r_mem[w_tail_m1];
  assign o_count     = r_count;
  assign o_full      = (r_count == CW'(DEPTH));
  assign o_empty     = (r_count == '0);

  always_ff @(posedge clk_i) begin
    if (i_push) r_mem[r_tail] <= i_push_data;
  end

  // Push and tail pop are never requested together by the controller.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_push)          r_tail <= r_tail + AW'(1);
      else if (i_pop_tail) r_tail <= w_tail_m1;
      if (i_pop_head)      r_head <= r_head + AW'(1);
      r_count <= r_count + CW'(i_push) - CW'(i_pop_head) - CW'(i_pop_tail);
    end
  end

endmodule

// File: rtl/ras_ctrl.sv
// RAS speculation controller: checkpoints fetch RAS ops, retires them in order
// and unwinds the survivors on flush. Optional perf counters: RAS_CTRL_PERF_EN.
module ras_ctrl
  import tcore_param::*;
#(
  parameter  int DEPTH = 8,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  input  ras_op_e          req_op_i,
  input  logic [XLEN-1:0]  req_top_i,
  output logic             req_ready_o,
  input  logic             retire_i,
  input  logic             flush_i,
  output logic             ras_cmd_valid_o,
  output ras_op_e          ras_cmd_op_o,
  output logic [XLEN-1:0]  ras_cmd_addr_o,
  output logic             busy_o,
  output logic             unwind_done_o,
  output logic [CW-1:0]    count_o
`ifdef RAS_CTRL_PERF_EN
  ,
  output logic [31:0]      perf_unwind_o,
  output logic [31:0]      perf_full_stall_o
`endif
);

  ras_ctrl_state_e  r_state, w_state_nxt;
  logic             w_accept, w_retire, w_pop_tail, w_cmd_load, w_done_nxt;
  logic             w_full, w_empty;
  logic [CW-1:0]    w_count;
  ras_ckpt_t        w_tail_data;
  ras_ckpt_t        r_cmd;
  logic             r_cmd_vld, r_done;

  ras_ckpt_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .i_push      (w_accept),
    .i_push_data ('{op: req_op_i, saved_top: req_top_i}),
    .i_pop_head  (w_retire),
    .i_pop_tail  (w_pop_tail),
    .o_tail_data (w_tail_data),
    .o_count     (w_count),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // The flush cycle already pops the youngest entry so the first corrective
  // command is registered and visible in the first UNWIND cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_retire    = 1'b0;
    w_pop_tail  = 1'b0;
    w_cmd_load  = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        w_retire = retire_i && !w_empty;
        if (flush_i) begin
          if (w_count != CW'(w_retire)) begin
            w_state_nxt = UNWIND;
            w_pop_tail  = 1'b1;
            w_cmd_load  = 1'b1;
          end else begin
            w_done_nxt  = 1'b1;
          end
        end else begin
          w_accept = req_valid_i && !w_full && (req_op_i != NONE);
        end
      end
      UNWIND: begin
        if (w_count != '0) begin
          w_pop_tail = 1'b1;
          w_cmd_load = 1'b1;
        end else begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cmd_vld <= 1'b0;
      r_cmd     <= '0;
      r_done    <= 1'b0;
    end else begin
      r_cmd_vld <= w_cmd_load;
      r_cmd     <= w_cmd_load ? ras_inverse(w_tail_data) : '0;
      r_done    <= w_done_nxt;
    end
  end

  assign req_ready_o     = !w_full && (r_state == IDLE);
  assign ras_cmd_valid_o = r_cmd_vld;
  assign ras_cmd_op_o    = r_cmd.op;
  assign ras_cmd_addr_o  = r_cmd.saved_top;
  assign busy_o          = (r_state == UNWIND);
  assign unwind_done_o   = r_done;
  assign count_o         = w_count;

`ifdef RAS_CTRL_PERF_EN
  logic [31:0] r_perf_unwind, r_perf_stall;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_perf_unwind <= '0;
      r_perf_stall  <= '0;
    end else begin
      if (r_state == IDLE && w_state_nxt == UNWIND && r_perf_unwind != '1)
        r_perf_unwind <= r_perf_unwind + 32'd1;
      if (req_valid_i && req_op_i != NONE && w_full && r_perf_stall != '1)
        r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_unwind_o     = r_perf_unwind;
  assign perf_full_stall_o = r_perf_stall;
`endif

  ap_retire_legal: assert property (@(posedge clk_i) disable iff (rst_i)
    !(retire_i && (r_state == UNWIND || w_empty)))
    else $error("ras_ctrl: retire while empty or during unwind");

endmodule

// File: tb/tb_ras_ctrl.sv
// Randomized bench for ras_ctrl: queue-level reference model plus a command
// scoreboard drained by an independent monitor.
module tb_ras_ctrl;
  import tcore_param::*;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid = 1'b0, retire = 1'b0, flush = 1'b0;
  ras_op_e          req_op = NONE;
  logic [XLEN-1:0]  req_top = '0;
  logic             req_ready, cmd_valid, busy, done;
  ras_op_e          cmd_op;
  logic [XLEN-1:0]  cmd_addr;
  logic [CW-1:0]    count;
`ifdef RAS_CTRL_PERF_EN
  logic [31:0]      perf_unwind, perf_stall;
`endif

  always #5 clk = ~clk;

  ras_ctrl #(.DEPTH(DEPTH)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .req_valid_i     (req_valid),
    .req_op_i        (req_op),
    .req_top_i       (req_top),
    .req_ready_o     (req_ready),
    .retire_i        (retire),
    .flush_i         (flush),
    .ras_cmd_valid_o (cmd_valid),
    .ras_cmd_op_o    (cmd_op),
    .ras_cmd_addr_o  (cmd_addr),
    .busy_o          (busy),
    .unwind_done_o   (done),
    .count_o         (count)
`ifdef RAS_CTRL_PERF_EN
    ,
    .perf_unwind_o     (perf_unwind),
    .perf_full_stall_o (perf_stall)
`endif
  );

  int        n_chk = 0, n_fail = 0;
  ras_ckpt_t mq[$];        // architecturally pending ops, oldest first
  ras_ckpt_t exp_cmd[$];   // corrective commands not yet seen
  int        ucnt = 0;     // unwind cycles still to come
  bit        e_done = 1'b0;
  int        m_unw = 0, m_stall = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic ras_ckpt_t undo_of(input ras_ckpt_t e);
    ras_ckpt_t c;
    case (e.op)
      PUSH:    c = '{op: POP,  saved_top: '0};
      POP:     c = '{op: PUSH, saved_top: e.saved_top};
      default: c = '{op: BOTH, saved_top: e.saved_top};
    endcase
    return c;
  endfunction

  // One clock: check this cycle's outputs, drive new inputs, advance the model.
  task automatic step(input bit v, input ras_op_e op, input logic [XLEN-1:0] top,
                      input bit ret, input bit fl, input bit r);
    int pre;
    @(posedge clk); #1;
    chk("count",     count,     (ucnt > 0) ? ucnt - 1 : mq.size());
    chk("busy",      busy,      ucnt > 0);
    chk("ready",     req_ready, (ucnt == 0) && (mq.size() < DEPTH));
    chk("cmd_valid", cmd_valid, ucnt > 0);
    chk("done",      done,      e_done);
    rst = r; req_valid = v; req_op = op; req_top = top; retire = ret; flush = fl;
    if (r) begin
      if (ucnt > 0) while (exp_cmd.size() > 1) void'(exp_cmd.pop_back());
      else exp_cmd.delete();
      mq.delete(); ucnt = 0; e_done = 1'b0; m_unw = 0; m_stall = 0;
    end else if (ucnt > 0) begin
      ucnt--;
      e_done = (ucnt == 0);
    end else begin
      pre = mq.size();
      e_done = 1'b0;
      if (v && op != NONE && pre == DEPTH) m_stall++;
      if (ret && pre > 0) void'(mq.pop_front());
      if (fl) begin
        for (int i = mq.size() - 1; i >= 0; i--) exp_cmd.push_back(undo_of(mq[i]));
        ucnt = mq.size();
        e_done = (ucnt == 0);
        if (ucnt > 0) m_unw++;
        mq.delete();
      end else if (v && op != NONE && pre < DEPTH) begin
        mq.push_back('{op: op, saved_top: top});
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, NONE, '0, 1'b0, 1'b0, 1'b0);
  endtask

  always @(negedge clk) begin : monitor
    ras_ckpt_t e;
    if (cmd_valid === 1'b1) begin
      if (exp_cmd.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL cmd_unexpected: got op %0d addr %0h, expected no command", cmd_op, cmd_addr);
      end else begin
        e = exp_cmd.pop_front();
        chk("cmd_op",   cmd_op,   e.op);
        chk("cmd_addr", cmd_addr, e.saved_top);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    bit v, ret, fl, r;
    ras_op_e op;
    step(1'b0, NONE, '0, 1'b0, 1'b0, 1'b1);
    step(1'b0, NONE, '0, 1'b0, 1'b0, 1'b1);
    // push, push, pop then flush
    step(1'b1, PUSH, 32'h100, 1'b0, 1'b0, 1'b0);
    step(1'b1, PUSH, 32'h200, 1'b0, 1'b0, 1'b0);
    step(1'b1, POP,  32'h200, 1'b0, 1'b0, 1'b0);
    step(1'b0, NONE, '0,      1'b0, 1'b1, 1'b0);
    idle(5);
    // retired op leaves nothing to unwind
    step(1'b1, PUSH, 32'h100, 1'b0, 1'b0, 1'b0);
    step(1'b0, NONE, '0,      1'b1, 1'b0, 1'b0);
    step(1'b0, NONE, '0,      1'b0, 1'b1, 1'b0);
    idle(3);
    // overfill: ninth push must be held
    for (int i = 0; i < 9; i++) step(1'b1, PUSH, 32'(i * 16 + 4), 1'b0, 1'b0, 1'b0);
    step(1'b1, PUSH, 32'hdead, 1'b0, 1'b0, 1'b0);
    step(1'b0, NONE, '0, 1'b0, 1'b1, 1'b0);
    idle(10);
    // accept BOTH with simultaneous retire at count 2
    step(1'b1, PUSH, 32'h10, 1'b0, 1'b0, 1'b0);
    step(1'b1, POP,  32'h20, 1'b0, 1'b0, 1'b0);
    step(1'b1, BOTH, 32'h300, 1'b1, 1'b0, 1'b0);
    step(1'b0, NONE, '0, 1'b0, 1'b1, 1'b0);
    idle(5);
    // reset in the second unwind cycle
    for (int i = 0; i < 3; i++) step(1'b1, POP, 32'(32'h500 + i), 1'b0, 1'b0, 1'b0);
    step(1'b0, NONE, '0, 1'b0, 1'b1, 1'b0);
    step(1'b1, PUSH, 32'h77, 1'b0, 1'b1, 1'b0);
    step(1'b0, NONE, '0, 1'b0, 1'b0, 1'b1);
    idle(3);
    // NONE requests are never recorded
    for (int i = 0; i < 10; i++) step(1'b1, NONE, $urandom, 1'b0, 1'b0, 1'b0);
    // random traffic; inputs during unwind are noise the DUT must ignore
    for (int i = 0; i < 3000; i++) begin
      v   = ($urandom_range(99) < 60);
      op  = ras_op_e'($urandom_range(3));
      fl  = ($urandom_range(99) < 4);
      r   = ($urandom_range(999) < 5);
      ret = ($urandom_range(99) < 20) && (ucnt == 0) && (mq.size() > 0);
      step(v, op, $urandom, ret, fl, r);
    end
    while (ucnt > 0) idle(1);
    idle(3);
    chk("cmds_drained", exp_cmd.size(), 0);
`ifdef RAS_CTRL_PERF_EN
    chk("perf_unwind", perf_unwind, m_unw);
    chk("perf_stall",  perf_stall,  m_stall);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
